// File: rtl/fetch_unit_if.sv
// Fetch unit bus: PC register control, instruction memory and decode handshake.
// master = fetch unit side, slave = environment side.
interface fetch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] i_pc;
    logic [1:0]        o_pc_op;
    logic [ADDR_W-1:0] o_pc_target;
    logic              i_redirect;
    logic [ADDR_W-1:0] i_redirect_pc;
    logic              o_mem_req;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              i_mem_ack;
    logic [DATA_W-1:0] i_mem_rdata;
    logic              o_instr_valid;
    logic [DATA_W-1:0] o_instr;
    logic [ADDR_W-1:0] o_instr_pc;
    logic              i_instr_ready;
    logic              o_fetch_err;

    modport master (
        input  i_pc, i_redirect, i_redirect_pc,
        input  i_mem_ack, i_mem_rdata, i_instr_ready,
        output o_pc_op, o_pc_target, o_mem_req, o_mem_addr,
        output o_instr_valid, o_instr, o_instr_pc, o_fetch_err
    );

    modport slave (
        output i_pc, i_redirect, i_redirect_pc,
        output i_mem_ack, i_mem_rdata, i_instr_ready,
        input  o_pc_op, o_pc_target, o_mem_req, o_mem_addr,
        input  o_instr_valid, o_instr, o_instr_pc, o_fetch_err
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer driving the PC register and instruction memory.
// Optional memory-ack timeout enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input logic          i_clk,
    input logic          i_rst,
    fetch_unit_if.master bus
);
    typedef enum logic [2:0] {CLR, REQ, HOLD, FLUSH, SYNC} state_t;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    state_t            state, state_n;
    logic [1:0]        pc_op, pc_op_n;
    logic [ADDR_W-1:0] pc_target, pc_target_n;
    logic              mem_req, mem_req_n;
    logic [ADDR_W-1:0] mem_addr, mem_addr_n;
    logic              instr_valid, instr_valid_n;
    logic [DATA_W-1:0] instr, instr_n;
    logic [ADDR_W-1:0] instr_pc, instr_pc_n;
    logic              fetch_err, fetch_err_n;
    logic              ack;
    logic              timeout_hit;

    // Acks are only meaningful against an outstanding request
    assign ack = bus.i_mem_ack & mem_req;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [8:0] LIM = 9'(TIMEOUT);

    logic [7:0] wait_cnt;
    logic [8:0] tick;
    logic       issue;
    logic       waiting;

    assign issue   = (state == SYNC) && !bus.i_redirect;
    assign waiting = (state == REQ) || (state == FLUSH);
    assign tick    = {1'b0, wait_cnt} + 9'd1;
    assign timeout_hit = waiting && !ack && (tick >= LIM);

    // Saturates at the limit so a redirect on the hit cycle still times out next
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wait_cnt <= '0;
        end else if (issue) begin
            wait_cnt <= '0;
        end else if (waiting && !ack) begin
            wait_cnt <= (tick >= LIM) ? LIM[7:0] : tick[7:0];
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^8'(TIMEOUT);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= CLR;
            pc_op       <= OP_CLR;
            pc_target   <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            fetch_err   <= 1'b0;
        end else begin
            state       <= state_n;
            pc_op       <= pc_op_n;
            pc_target   <= pc_target_n;
            mem_req     <= mem_req_n;
            mem_addr    <= mem_addr_n;
            instr_valid <= instr_valid_n;
            instr       <= instr_n;
            instr_pc    <= instr_pc_n;
            fetch_err   <= fetch_err_n;
        end
    end

    always_comb begin
        state_n       = state;
        pc_op_n       = OP_HOLD;
        pc_target_n   = pc_target;
        mem_req_n     = mem_req;
        mem_addr_n    = mem_addr;
        instr_valid_n = instr_valid;
        instr_n       = instr;
        instr_pc_n    = instr_pc;
        fetch_err_n   = 1'b0;

        unique case (state)
            CLR: begin
                state_n = SYNC;
            end
            SYNC: begin
                if (bus.i_redirect) begin
                    pc_op_n     = OP_LOAD;
                    pc_target_n = bus.i_redirect_pc;
                end else begin
                    mem_req_n  = 1'b1;
                    mem_addr_n = bus.i_pc;
                    state_n    = REQ;
                end
            end
            REQ: begin
                if (bus.i_redirect) begin
                    pc_op_n       = OP_LOAD;
                    pc_target_n   = bus.i_redirect_pc;
                    instr_valid_n = 1'b0;
                    if (ack) begin
                        mem_req_n = 1'b0;
                        state_n   = SYNC;
                    end else begin
                        state_n   = FLUSH;
                    end
                end else if (ack) begin
                    mem_req_n     = 1'b0;
                    instr_n       = bus.i_mem_rdata;
                    instr_pc_n    = mem_addr;
                    instr_valid_n = 1'b1;
                    pc_op_n       = OP_INC;
                    state_n       = HOLD;
                end else if (timeout_hit) begin
                    // Hand decode a NOP so the stalled slot is still retired
                    mem_req_n     = 1'b0;
                    instr_n       = '0;
                    instr_pc_n    = mem_addr;
                    instr_valid_n = 1'b1;
                    fetch_err_n   = 1'b1;
                    pc_op_n       = OP_INC;
                    state_n       = HOLD;
                end
            end
            HOLD: begin
                if (bus.i_redirect) begin
                    pc_op_n       = OP_LOAD;
                    pc_target_n   = bus.i_redirect_pc;
                    instr_valid_n = 1'b0;
                    state_n       = SYNC;
                end else if (bus.i_instr_ready) begin
                    instr_valid_n = 1'b0;
                    state_n       = SYNC;
                end
            end
            FLUSH: begin
                if (bus.i_redirect) begin
                    pc_op_n     = OP_LOAD;
                    pc_target_n = bus.i_redirect_pc;
                    if (ack) begin
                        mem_req_n = 1'b0;
                        state_n   = SYNC;
                    end
                end else if (ack) begin
                    mem_req_n = 1'b0;
                    state_n   = SYNC;
                end else if (timeout_hit) begin
                    mem_req_n   = 1'b0;
                    fetch_err_n = 1'b1;
                    state_n     = SYNC;
                end
            end
            default: begin
                state_n = CLR;
            end
        endcase
    end

    assign bus.o_pc_op       = pc_op;
    assign bus.o_pc_target   = pc_target;
    assign bus.o_mem_req     = mem_req;
    assign bus.o_mem_addr    = mem_addr;
    assign bus.o_instr_valid = instr_valid;
    assign bus.o_instr       = instr;
    assign bus.o_instr_pc    = instr_pc;
    assign bus.o_fetch_err   = fetch_err;
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit with PC register, memory and decode models.
// Define FETCH_TIMEOUT_EN to also cover the ack timeout.
module tb_fetch_unit;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // environment state
    logic [15:0] pc_reg = 16'h1234;
    bit          mem_busy = 0;
    int          mem_wait = 0;
    int          force_delay = -1;
    bit          force_data_en = 0;
    logic [15:0] force_data = '0;

    // reference model: what the fetch unit should be showing
    bit          m_clear, m_bubble, m_squash;
    logic        m_req, m_valid, m_err;
    logic [1:0]  m_op;
    logic [15:0] m_tgt, m_addr, m_instr, m_ipc;
    int          m_wait;

    // monitors for directed checks
    logic [15:0] req_log[$];
    logic [15:0] vlog_instr[$];
    logic [15:0] vlog_pc[$];
    int          inc_cnt, addr_jumps, instr_jumps;
    bit          saw_beef;
    logic        p_req, p_valid;
    logic [15:0] p_addr, p_instr, p_ipc;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_clear = 1; m_bubble = 0; m_squash = 0;
        m_req = 0; m_valid = 0; m_err = 0; m_op = 2'b11;
        m_tgt = 0; m_addr = 0; m_instr = 0; m_ipc = 0; m_wait = 0;
    endtask

    // One clock of the fetch rules, stated in terms of outstanding work
    task automatic model_step(input bit redir, input logic [15:0] rpc,
                              input bit ack, input logic [15:0] rd,
                              input bit rdy, input logic [15:0] pc);
        bit acked;
        acked = ack && m_req;
        m_op = 2'b00;
        m_err = 0;
        if (m_req && !acked) m_wait++;
        if (m_clear) begin
            m_clear = 0; m_bubble = 1;
        end else if (redir) begin
            m_op = 2'b10; m_tgt = rpc; m_valid = 0;
            if (m_req && !acked) m_squash = 1;
            else begin m_req = 0; m_squash = 0; m_bubble = 1; end
        end else if (m_req) begin
            if (acked) begin
                m_req = 0;
                if (m_squash) begin m_squash = 0; m_bubble = 1; end
                else begin
                    m_valid = 1; m_instr = rd; m_ipc = m_addr; m_op = 2'b01;
                end
            end
`ifdef FETCH_TIMEOUT_EN
            else if (m_wait >= TO) begin
                m_req = 0; m_err = 1;
                if (m_squash) begin m_squash = 0; m_bubble = 1; end
                else begin
                    m_valid = 1; m_instr = 0; m_ipc = m_addr; m_op = 2'b01;
                end
            end
`endif
        end else if (m_valid) begin
            if (rdy) begin m_valid = 0; m_bubble = 1; end
        end else if (m_bubble) begin
            m_req = 1; m_addr = pc; m_bubble = 0; m_wait = 0;
        end
    endtask

    task automatic compare_all();
        chk("pc_op", 32'(bus.o_pc_op), 32'(m_op));
        chk("pc_target", 32'(bus.o_pc_target), 32'(m_tgt));
        chk("mem_req", 32'(bus.o_mem_req), 32'(m_req));
        chk("mem_addr", 32'(bus.o_mem_addr), 32'(m_addr));
        chk("instr_valid", 32'(bus.o_instr_valid), 32'(m_valid));
        chk("instr", 32'(bus.o_instr), 32'(m_instr));
        chk("instr_pc", 32'(bus.o_instr_pc), 32'(m_ipc));
        chk("fetch_err", 32'(bus.o_fetch_err), 32'(m_err));
    endtask

    task automatic monitor();
        if (bus.o_mem_req && !p_req) req_log.push_back(bus.o_mem_addr);
        if (bus.o_mem_req && p_req && bus.o_mem_addr != p_addr) addr_jumps++;
        if (bus.o_instr_valid && p_valid &&
            (bus.o_instr != p_instr || bus.o_instr_pc != p_ipc)) instr_jumps++;
        if (bus.o_instr_valid && !p_valid) begin
            vlog_instr.push_back(bus.o_instr);
            vlog_pc.push_back(bus.o_instr_pc);
        end
        if (bus.o_pc_op == 2'b01) inc_cnt++;
        if (bus.o_instr_valid && bus.o_instr == 16'hBEEF) saw_beef = 1;
        p_req = bus.o_mem_req; p_addr = bus.o_mem_addr;
        p_valid = bus.o_instr_valid; p_instr = bus.o_instr;
        p_ipc = bus.o_instr_pc;
    endtask

    task automatic step(input bit redir, input logic [15:0] rpc, input bit rdy);
        bit          ack;
        logic [15:0] rd;
        @(negedge clk);
        case (bus.o_pc_op)
            2'b01:   pc_reg = pc_reg + 16'd1;
            2'b10:   pc_reg = bus.o_pc_target;
            2'b11:   pc_reg = '0;
            default: ;
        endcase
        if (!bus.o_mem_req) begin
            mem_busy = 0;
            ack = ($urandom_range(0, 7) == 0);
        end else begin
            if (!mem_busy) begin
                mem_busy = 1;
                mem_wait = (force_delay >= 0) ? force_delay
                                              : int'($urandom_range(0, 4));
            end
            if (mem_wait == 0) begin ack = 1; mem_busy = 0; end
            else begin ack = 0; mem_wait--; end
        end
        rd = 16'($urandom);
        if (rd == 16'hBEEF) rd = 16'hBEEE;
        if (force_data_en) rd = force_data;
        bus.i_pc = pc_reg;
        bus.i_redirect = redir;
        bus.i_redirect_pc = rpc;
        bus.i_mem_ack = ack;
        bus.i_mem_rdata = rd;
        bus.i_instr_ready = rdy;
        @(posedge clk);
        if (!rst) model_step(redir, rpc, ack, rd, rdy, pc_reg);
        #1;
        compare_all();
        monitor();
    endtask

    task automatic wait_req(input bit rdy, output logic [15:0] a);
        int n0;
        n0 = req_log.size();
        a = 'x;
        for (int k = 0; k < 80; k++) begin
            step(0, '0, rdy);
            if (req_log.size() > n0) break;
        end
        if (req_log.size() > n0) a = req_log[$];
        else chk("wait_req_timeout", 0, 1);
    endtask

    logic [15:0] a;
    bit          seen;

    initial begin
        model_reset();
        p_req = 0; p_valid = 0; p_addr = 0; p_instr = 0; p_ipc = 0;
        inc_cnt = 0; addr_jumps = 0; instr_jumps = 0; saw_beef = 0;
        bus.i_pc = pc_reg; bus.i_redirect = 0; bus.i_redirect_pc = '0;
        bus.i_mem_ack = 0; bus.i_mem_rdata = '0; bus.i_instr_ready = 0;

        // reset: clear code held, everything else idle
        for (int i = 0; i < 3; i++) step(1, 16'h7777, 1);
        chk("rst_pc_op", 32'(bus.o_pc_op), 32'h3);
        chk("rst_req", 32'(bus.o_mem_req), 32'h0);
        chk("rst_pc_cleared", 32'(pc_reg), 32'h0);
        rst = 1'b0;

        // first fetch, same-cycle ack, ready high
        force_delay = 0; force_data_en = 1; force_data = 16'hA001;
        inc_cnt = 0;
        wait_req(1, a);
        chk("t1_req0", 32'(a), 32'h0000);
        wait_req(1, a);
        chk("t1_req1", 32'(a), 32'h0001);
        if (vlog_instr.size() > 0) begin
            chk("t1_instr", 32'(vlog_instr[0]), 32'hA001);
            chk("t1_ipc", 32'(vlog_pc[0]), 32'h0000);
        end else chk("t1_valid_seen", 0, 1);
        chk("t1_inc", 32'(inc_cnt), 32'd1);
        force_data_en = 0;

        // slow ack and stalled decode
        force_delay = 4; inc_cnt = 0; addr_jumps = 0; instr_jumps = 0;
        for (int i = 0; i < 8; i++) step(0, '0, 0);
        chk("t2_held", 32'(bus.o_instr_valid), 32'h1);
        step(0, '0, 1);
        wait_req(1, a);
        chk("t2_next_req", 32'(a), 32'h0002);
        chk("t2_inc", 32'(inc_cnt), 32'd1);
        chk("t2_addr_stable", 32'(addr_jumps), 32'd0);
        chk("t2_instr_stable", 32'(instr_jumps), 32'd0);

        // redirect while holding an instruction
        force_delay = 0;
        step(1, 16'h0005, 0);
        for (int k = 0; k < 40 && !bus.o_instr_valid; k++) step(0, '0, 0);
        chk("t3_ipc", 32'(bus.o_instr_pc), 32'h0005);
        step(1, 16'h0040, 1);
        chk("t3_valid_drop", 32'(bus.o_instr_valid), 32'h0);
        chk("t3_op", 32'(bus.o_pc_op), 32'h2);
        chk("t3_target", 32'(bus.o_pc_target), 32'h0040);
        wait_req(1, a);
        chk("t3_req", 32'(a), 32'h0040);

        // redirect during an outstanding read
        force_delay = 2; force_data_en = 1; force_data = 16'hBEEF;
        inc_cnt = 0; saw_beef = 0;
        step(1, 16'h0100, 1);
        wait_req(1, a);
        force_data_en = 0;
        chk("t4_req", 32'(a), 32'h0100);
        chk("t4_no_beef", 32'(saw_beef), 32'h0);
        chk("t4_no_inc", 32'(inc_cnt), 32'd0);

        // fetch at top of address space wraps
        force_delay = 0;
        step(1, 16'hFFFF, 1);
        wait_req(1, a);
        chk("t5_req_top", 32'(a), 32'hFFFF);
        inc_cnt = 0;
        wait_req(1, a);
        chk("t5_req_wrap", 32'(a), 32'h0000);
        chk("t5_inc", 32'(inc_cnt), 32'd1);

`ifdef FETCH_TIMEOUT_EN
        // memory never answers
        force_delay = 1000;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            step(0, '0, 1);
            if (bus.o_fetch_err) begin
                seen = 1;
                chk("t6_cycles", 32'(k + 1), 32'(TO));
                chk("t6_nop", 32'(bus.o_instr), 32'h0);
                chk("t6_valid", 32'(bus.o_instr_valid), 32'h1);
                chk("t6_ipc", 32'(bus.o_instr_pc), 32'(req_log[$]));
                break;
            end
        end
        chk("t6_err_seen", 32'(seen), 32'h1);
`endif

        // randomized traffic
        force_delay = -1;
        for (int i = 0; i < 500; i++)
            step($urandom_range(0, 11) == 0, 16'($urandom),
                 $urandom_range(0, 2) != 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
